alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU. Logic, add/sub and shift ops finish in one cycle.
// MUL and (optionally) DIVU/REMU iterate one bit per cycle. The result is held in an output
// register until the consumer takes it.
// Optional feature: define ALU_SEQ_DIV_EN to build the iterative unsigned divider. Without
// it, DIVU/REMU behave like the reserved opcodes (result = A, single cycle).
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam logic [3:0] OpSll  = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpAnd  = 4'b0011;
  localparam logic [3:0] OpOr   = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpMul  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSrl  = 4'b1000;
  localparam logic [3:0] OpDivu = 4'b1001;
  localparam logic [3:0] OpRemu = 4'b1010;

`ifdef ALU_SEQ_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  // acc: MUL partial product / DIV partial remainder.
  // sh:  MUL multiplier (shifts right) / DIV dividend-then-quotient (shifts left).
  // opb: MUL multiplicand (shifts left) / DIV divisor.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             zpend_q, zpend_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  // Holds ready_o low during reset and releases it on the first edge afterwards.
  logic             live_q;

  logic             accept;
  logic             is_iter;
  logic             operand_eq;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_acc;

  assign ready_o    = live_q & ((state_q == StIdle) | ((state_q == StDone) & ready_i));
  assign valid_o    = (state_q == StDone);
  assign data_o     = data_q;
  assign Zero_o     = zero_q;
  assign accept     = valid_i & ready_o;
  assign operand_eq = (data1_i == data2_i);
  assign shamt      = data2_i[SHW-1:0];
  assign is_iter    = (ALUCtrl_i == OpMul) |
                      (DivEn & ((ALUCtrl_i == OpDivu) | (ALUCtrl_i == OpRemu)));
  assign mul_acc    = acc_q + (sh_q[0] ? opb_q : '0);

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  // One restoring-division step: bring down the next dividend bit, subtract if it fits.
  assign div_trial = {acc_q, sh_q[WIDTH-1]} - {1'b0, opb_q};
  assign div_ge    = ~div_trial[WIDTH];
  assign div_rem   = div_ge ? div_trial[WIDTH-1:0] : {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
  assign div_quo   = {sh_q[WIDTH-2:0], div_ge};
`endif

  // Single-cycle result for the opcode currently presented.
  always_comb begin
    alu_res = data1_i;
    case (ALUCtrl_i)
      OpSll:   alu_res = data1_i << shamt;
      OpAdd:   alu_res = data1_i + data2_i;
      OpSub:   alu_res = data1_i - data2_i;
      OpAnd:   alu_res = data1_i & data2_i;
      OpOr:    alu_res = data1_i | data2_i;
      OpXor:   alu_res = data1_i ^ data2_i;
      OpSra:   alu_res = WIDTH'($signed(data1_i) >>> shamt);
      OpSrl:   alu_res = data1_i >> shamt;
      default: alu_res = data1_i;
    endcase
  end

  // Next-state: accept/handshake control and one iteration step per cycle in BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opb_d   = opb_q;
    zpend_d = zpend_q;
    data_d  = data_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle, StDone: begin
        if ((state_q == StDone) && ready_i) state_d = StIdle;
        if (accept) begin
          if (is_iter) begin
            state_d = StBusy;
            cnt_d   = '0;
            op_d    = ALUCtrl_i;
            zpend_d = operand_eq;
            acc_d   = '0;
            sh_d    = (ALUCtrl_i == OpMul) ? data2_i : data1_i;
            opb_d   = (ALUCtrl_i == OpMul) ? data1_i : data2_i;
          end else begin
            state_d = StDone;
            data_d  = alu_res;
            zero_d  = operand_eq;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OpMul) begin
          acc_d = mul_acc;
          sh_d  = sh_q >> 1;
          opb_d = opb_q << 1;
        end
`ifdef ALU_SEQ_DIV_EN
        else begin
          acc_d = div_rem;
          sh_d  = div_quo;
        end
`endif
        if (cnt_q == CntLast) begin
          state_d = StDone;
          zero_d  = zpend_q;
          data_d  = mul_acc;
`ifdef ALU_SEQ_DIV_EN
          if (op_q == OpDivu) data_d = div_quo;
          if (op_q == OpRemu) data_d = div_rem;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opb_q   <= '0;
      zpend_q <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opb_q   <= opb_d;
      zpend_q <= zpend_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH = 32). Expected results are queued when an operation
// is driven and compared when the result handshake happens. Honours ALU_SEQ_DIV_EN.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk_i;
  logic          rst_n_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  data1_i;
  logic [W-1:0]  data2_i;
  logic [3:0]    ALUCtrl_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  data_o;
  logic          Zero_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q_data[$];
  logic         q_zero[$];
  string        q_tag[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .ALUCtrl_i (ALUCtrl_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a << sh;
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return a * b;
      4'd7:  return W'($signed(a) >>> sh);
      4'd8:  return a >> sh;
`ifdef ALU_SEQ_DIV_EN
      4'd9:  return (b == 0) ? {W{1'b1}} : a / b;
      4'd10: return (b == 0) ? a : a % b;
`endif
      default: return a;
    endcase
  endfunction

  // Called right after a falling edge; returns right after the falling edge following accept.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] exp, input string tag);
    bit ok;
    ok        = 1'b0;
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    q_data.push_back(exp);
    q_zero.push_back(a == b);
    q_tag.push_back(tag);
    for (int n = 0; n < 200; n++) begin
      #1;
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    check({"accept_", tag}, ok, 1);
    @(negedge clk_i);
    valid_i   = 1'b0;
    data1_i   = $urandom;
    data2_i   = $urandom;
    ALUCtrl_i = 4'($urandom_range(0, 15));
  endtask

  // Counts cycles until valid_o rises; returns 100 on timeout.
  task automatic wait_valid(output int n, output bit busy_ok);
    n       = 0;
    busy_ok = 1'b1;
    while (n < 100) begin
      #1;
      if (valid_o) break;
      if (ready_o) busy_ok = 1'b0;
      n++;
      @(negedge clk_i);
    end
  endtask

  // Result monitor: a handshake at the coming rising edge pops one expectation.
  initial begin : monitor
    forever begin
      @(negedge clk_i);
      #2;
      if (valid_o && ready_i) begin
        if (q_data.size() == 0) begin
          check("unexpected_result", q_data.size(), 1);
        end else begin
          check(q_tag.pop_front(), {Zero_o, data_o}, {q_zero.pop_front(), q_data.pop_front()});
        end
      end
    end
  end

  initial begin : stim
    int  n;
    bit  busy_ok;
    logic [3:0]   op;
    logic [W-1:0] a, b;

    rst_n_i   = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    data1_i   = '0;
    data2_i   = '0;
    ALUCtrl_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    check("reset_state", {ready_o, valid_o, Zero_o, data_o}, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check("ready_before_first_edge", ready_o, 0);
    @(negedge clk_i);
    #1;
    check("ready_after_release", {ready_o, valid_o}, 2'b10);

    // Single-cycle ops, latency 1.
    @(negedge clk_i);
    send(4'd1, 32'd5, 32'd7, 32'd12, "add_5_7");
    #1;
    check("add_latency", {valid_o, Zero_o, data_o}, {1'b1, 1'b0, 32'd12});
    @(negedge clk_i);
    send(4'd2, 32'h1234, 32'h1234, 32'd0, "sub_eq");
    send(4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    send(4'd0, 32'd1, 32'h25, 32'h20, "sll_mask");
    send(4'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, "xor");
    send(4'd15, 32'hCAFE_0001, 32'd3, 32'hCAFE_0001, "reserved_op");

    // Iterative multiply.
    send(4'd6, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, "mul");
    wait_valid(n, busy_ok);
    check("mul_latency", n, W);
    check("mul_busy_not_ready", busy_ok, 1);

    // Divide / remainder.
    @(negedge clk_i);
`ifdef ALU_SEQ_DIV_EN
    send(4'd9, 32'd100, 32'd7, 32'd14, "divu_100_7");
    wait_valid(n, busy_ok);
    check("divu_latency", n, W);
    @(negedge clk_i);
    send(4'd10, 32'd100, 32'd7, 32'd2, "remu_100_7");
    wait_valid(n, busy_ok);
    @(negedge clk_i);
    send(4'd9, 32'd9, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    wait_valid(n, busy_ok);
    check("divu_by0_latency", n, W);
    @(negedge clk_i);
    send(4'd10, 32'd9, 32'd0, 32'd9, "remu_by0");
    wait_valid(n, busy_ok);
    @(negedge clk_i);
`else
    send(4'd9, 32'd100, 32'd7, 32'd100, "divu_nodiv");
    #1;
    check("divu_nodiv_latency", {valid_o, data_o}, {1'b1, 32'd100});
    @(negedge clk_i);
    send(4'd10, 32'd100, 32'd7, 32'd100, "remu_nodiv");
    #1;
    check("remu_nodiv_latency", valid_o, 1);
    @(negedge clk_i);
`endif

    // Backpressure, then simultaneous result and request handshakes.
    ready_i = 1'b0;
    send(4'd1, 32'd1, 32'd1, 32'd2, "bp_add");
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold", {valid_o, ready_o, Zero_o, data_o}, {1'b1, 1'b0, 1'b1, 32'd2});
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    send(4'd5, 32'hF0, 32'hFF, 32'h0F, "bp_xor");
    #1;
    check("bp_next", {valid_o, data_o}, {1'b1, 32'h0F});

    // Reset in the middle of a multiply.
    @(negedge clk_i);
    send(4'd6, 32'd1234, 32'd5678, 32'd7006652, "mul_aborted");
    repeat (9) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check("abort_outputs", {ready_o, valid_o, Zero_o, data_o}, 0);
    q_data.delete();
    q_zero.delete();
    q_tag.delete();
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      check("post_abort_idle", {ready_o, valid_o, data_o}, {1'b1, 1'b0, 32'd0});
    end

    // Random operations, back to back.
    @(negedge clk_i);
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? a : $urandom);
      send(op, a, b, model(op, a, b), $sformatf("rand%0d_op%0d", i, op));
    end

    for (int i = 0; i < 200 && q_data.size() > 0; i++) @(negedge clk_i);
    check("drain_pending", q_data.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
